if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Holds the program counter and a word-addressed instruction memory, and drives the IF/ID pipeline register consumed by the decode stage.
- Accepts stall, flush and branch-redirect controls from later stages.
- Provides a program-load write port, usable only while the pipeline is disabled.

Parameters:
DATA_W, 32, instruction and PC width
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of two)
RESET_PC, 32'h00000000, PC value after reset

Ports:
clk  in  1  clock; all state updates on rising edge
pc_reset  in  1  synchronous reset, active-low
pc_enable  in  1  1 = pipeline runs; 0 = freeze and allow program load
stall  in  1  hold PC and IF/ID (load-use hazard)
flush  in  1  insert bubble into IF/ID
branch_taken  in  1  redirect PC to branch_target
branch_target  in  DATA_W  redirect byte address
imem_we  in  1  instruction memory write strobe
imem_waddr  in  $clog2(IMEM_DEPTH)  word index to write
imem_wdata  in  DATA_W  instruction word to write
pc_addr_out  out  DATA_W  current PC (combinational from PC register)
pc_instr_out  out  DATA_W  instruction at current PC (combinational read)
if_id_pc_plus4  out  DATA_W  registered PC+4 of the fetched instruction
if_id_instr  out  DATA_W  registered fetched instruction
if_id_valid  out  1  1 = IF/ID holds a real instruction
halted  out  1  sticky halt flag (see Optional Feature)

Behaviour:
- Reset: one clock and reset input. Reset is synchronous and active-low: pc_reset=0 at a rising edge of clk gives PC=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, halted=0.
- Reset does not clear the memory; its contents survive reset.
- Addressing: PC is a byte address; word index = PC[$clog2(IMEM_DEPTH)+1:2]. If PC >= IMEM_DEPTH*4, pc_instr_out = 0 (NOP).
- Per-edge priority, highest first:
  1. Reset.
  2. pc_enable=0: PC and IF/ID hold.
  3. branch_taken=1: PC <= {branch_target[31:2],2'b00}; IF/ID <= bubble (instr 0, pc_plus4 0, valid 0).
  4. flush=1: IF/ID <= bubble; PC holds.
  5. stall=1: PC and IF/ID hold.
  6. Normal: PC <= PC+4; if_id_instr <= pc_instr_out; if_id_pc_plus4 <= PC+4; if_id_valid <= 1.
- Simultaneous controls:
  - branch_taken overrides stall and flush.
  - flush overrides stall.
- Latency: an instruction appears on if_id_instr exactly one edge after its PC is presented.
- PC+4 arithmetic is modulo 2^32 and wraps 32'hFFFFFFFC -> 0.
- Program load:
  - imem_we=1 writes imem[imem_waddr] <= imem_wdata at the edge, only when pc_enable=0. Writes are ignored when pc_enable=1.
  - Read of the written word shows old data before the edge and new data after it.
  - A write during reset with pc_enable=0 is still performed.
- Reset mid-operation: the next edge with pc_reset=0 restarts fetch at RESET_PC; any in-flight IF/ID content is discarded (valid=0).

Optional Feature:
- Macro: IF_STAGE_HALT_EN.
- Defined:
  - Word 32'hFFFFFFFF is HALT. When a normal-case edge (priority 6) latches HALT into IF/ID (valid=1), PC holds and halted <= 1.
  - While halted=1, PC holds and IF/ID <= bubble every enabled edge, regardless of stall, flush or branch_taken.
  - Only reset clears halted.
- Undefined: 32'hFFFFFFFF is an ordinary instruction; the halted port remains and is tied to 0.

Test Plan:
1. With pc_enable=0, load imem[0..3] = 0x11,0x22,0x33,0x44; pulse pc_reset low one cycle; set pc_enable=1 -> pc_addr_out 0,4,8,12 on successive cycles; if_id_instr 0x11,0x22,0x33 one edge later; if_id_pc_plus4 4,8,12; if_id_valid=1 from first enabled edge.
2. stall=1 for 2 cycles when PC=8 -> PC stays 8 and if_id_instr stays 0x22 for 2 edges; then resumes 0x33.
3. branch_taken=1, branch_target=0x00000007 at PC=12, stall=1 -> next PC=0x4, if_id_valid=0, if_id_instr=0; next edge if_id_instr=0x22.
4. Drop pc_enable mid-run at PC=8 -> all outputs frozen; imem_we writes 0x99 to word 5 and it is accepted. Re-enable and branch to 0x14 -> if_id_instr=0x99. A write attempted with pc_enable=1 leaves memory unchanged.
5. Branch to 0x100 (IMEM_DEPTH=64) -> pc_instr_out=0; next edge if_id_instr=0, valid=1. pc_reset=0 at PC=0x104 -> PC=0, valid=0, imem[0] still 0x11.
6. IF_STAGE_HALT_EN defined, imem[2]=0xFFFFFFFF -> after fetch at PC=8: halted=1, PC stays 8, following edges if_id_valid=0. Macro undefined -> halted=0 and PC advances to 12.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Holds the program counter and a word-addressed instruction memory. Drives
// the IF/ID pipeline register that the decode stage reads. Later stages can
// stall, flush or redirect it. While the pipeline is disabled, a
// program-load port can write the instruction memory.
//
// Optional feature macro: IF_STAGE_HALT_EN
//   defined   : the word 32'hFFFFFFFF is a HALT instruction. Fetching it
//               sets the sticky 'halted' flag. Only reset clears the flag.
//   undefined : 32'hFFFFFFFF is an ordinary instruction and 'halted' is 0.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   pc_reset       in   synchronous reset, active-low
//   pc_enable      in   1 = pipeline runs, 0 = freeze and allow program load
//   stall          in   hold PC and IF/ID
//   flush          in   put a bubble into IF/ID
//   branch_taken   in   redirect PC to branch_target
//   branch_target  in   redirect byte address (low two bits ignored)
//   imem_we        in   instruction memory write strobe
//   imem_waddr     in   word index to write
//   imem_wdata     in   instruction word to write
//   pc_addr_out    out  current PC
//   pc_instr_out   out  instruction at the current PC (combinational read)
//   if_id_pc_plus4 out  registered PC+4 of the fetched instruction
//   if_id_instr    out  registered fetched instruction
//   if_id_valid    out  1 = IF/ID holds a real instruction
//   halted         out  sticky halt flag
// ----------------------------------------------------------------------------
module if_stage #(
   parameter int                DATA_W     = 32,
   parameter int                IMEM_DEPTH = 64,
   parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          pc_reset,
   input  logic                          pc_enable,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          branch_taken,
   input  logic [DATA_W-1:0]             branch_target,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [DATA_W-1:0]             imem_wdata,
   output logic [DATA_W-1:0]             pc_addr_out,
   output logic [DATA_W-1:0]             pc_instr_out,
   output logic [DATA_W-1:0]             if_id_pc_plus4,
   output logic [DATA_W-1:0]             if_id_instr,
   output logic                          if_id_valid,
   output logic                          halted
);

   localparam int AW = $clog2(IMEM_DEPTH);

   // The mask clears the two byte-offset bits, so every PC is word aligned.
   localparam logic [DATA_W-1:0] ALIGN_MASK = ~(DATA_W'(3));

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] imem [IMEM_DEPTH];

   logic [DATA_W-1:0] pc_reg,        pc_next;
   logic [DATA_W-1:0] ifid_instr_reg, ifid_instr_next;
   logic [DATA_W-1:0] ifid_pc4_reg,   ifid_pc4_next;
   logic              ifid_valid_reg, ifid_valid_next;

   logic [DATA_W-1:0] pc_plus4;
   logic [AW-1:0]     word_idx;
   logic              in_range;
   logic [DATA_W-1:0] fetch_word;
   logic              halt_active;
   logic              halt_hit;

   // ------------------------------------------------------------------------
   // Fetch path
   // ------------------------------------------------------------------------
   // PC+4 wraps modulo 2^DATA_W, so 32'hFFFFFFFC + 4 = 0.
   assign pc_plus4 = pc_reg + DATA_W'(4);
   assign word_idx = pc_reg[AW+1:2];

   // Addresses past the end of memory read as NOP (0). Any address bit above
   // the word-index field puts the PC out of range.
   assign in_range   = ((pc_reg >> (AW + 2)) == '0);
   assign fetch_word = in_range ? imem[word_idx] : '0;

   // ------------------------------------------------------------------------
   // Optional halt support
   // ------------------------------------------------------------------------
`ifdef IF_STAGE_HALT_EN
   localparam logic [DATA_W-1:0] HALT_WORD = '1;

   logic halted_reg, halted_next;

   assign halt_active = halted_reg;
   assign halt_hit    = (fetch_word == HALT_WORD);

   always_comb begin
      halted_next = halted_reg;
      // HALT only takes effect when it enters IF/ID on a normal fetch edge.
      // A redirect, flush or stall on the same edge discards or holds the
      // fetch, so the flag does not change.
      if (pc_enable && !halted_reg && !branch_taken && !flush && !stall &&
          halt_hit) begin
         halted_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!pc_reset) begin
         halted_reg <= 1'b0;
      end else begin
         halted_reg <= halted_next;
      end
   end

   assign halted = halted_reg;
`else
   assign halt_active = 1'b0;
   assign halt_hit    = 1'b0;
   assign halted      = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state selection (reset is applied in the register block below)
   // ------------------------------------------------------------------------
   always_comb begin
      pc_next         = pc_reg;
      ifid_instr_next = ifid_instr_reg;
      ifid_pc4_next   = ifid_pc4_reg;
      ifid_valid_next = ifid_valid_reg;

      if (!pc_enable) begin
         // Frozen: everything holds so that the program can be loaded.
      end else if (halt_active) begin
         // Once halted, only bubbles flow. Branch, flush and stall have
         // no effect.
         ifid_instr_next = '0;
         ifid_pc4_next   = '0;
         ifid_valid_next = 1'b0;
      end else if (branch_taken) begin
         pc_next         = branch_target & ALIGN_MASK;
         ifid_instr_next = '0;
         ifid_pc4_next   = '0;
         ifid_valid_next = 1'b0;
      end else if (flush) begin
         ifid_instr_next = '0;
         ifid_pc4_next   = '0;
         ifid_valid_next = 1'b0;
      end else if (stall) begin
         // Load-use hazard: PC and IF/ID hold.
      end else begin
         ifid_instr_next = fetch_word;
         ifid_pc4_next   = pc_plus4;
         ifid_valid_next = 1'b1;
         // A fetched HALT freezes the PC on the HALT word itself.
         if (!halt_hit) begin
            pc_next = pc_plus4;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!pc_reset) begin
         pc_reg         <= RESET_PC;
         ifid_instr_reg <= '0;
         ifid_pc4_reg   <= '0;
         ifid_valid_reg <= 1'b0;
      end else begin
         pc_reg         <= pc_next;
         ifid_instr_reg <= ifid_instr_next;
         ifid_pc4_reg   <= ifid_pc4_next;
         ifid_valid_reg <= ifid_valid_next;
      end
   end

   // ------------------------------------------------------------------------
   // Instruction memory write port. Reset does not touch the memory, so a
   // program survives reset. A write while reset is asserted still goes
   // through, as long as the pipeline is disabled.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (imem_we && !pc_enable) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign pc_addr_out    = pc_reg;
   assign pc_instr_out   = fetch_word;
   assign if_id_instr    = ifid_instr_reg;
   assign if_id_pc_plus4 = ifid_pc4_reg;
   assign if_id_valid    = ifid_valid_reg;

endmodule
